sram_sample_fifo: RTL
=====================

Name: sram_sample_fifo

Overview:
Ring-buffer controller that turns external 256K x16 SRAM into a large audio sample FIFO between the I2S deserializer (producer) and the I2S serializer (consumer). Sits directly upstream of the SRAM pin-interface block and drives its read/write address, write data and doRead/doWrite strobes. Sequences one SRAM access at a time, with fixed setup/strobe/hold timing, and captures read data back. Exposes valid/ready streaming on both sample sides.

Parameters:
ADDR_W, 18, SRAM word-address width; buffer depth is 2**ADDR_W words
STROBE_CYC, 2, clk cycles doWrite/doRead held high (1..7)
HI_MARK, 131072, fill level for level_hi (watermark feature only)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  producer sample valid
in_ready  out  1  FIFO accepts sample this cycle
in_data  in  16  producer sample
out_valid  out  1  consumer sample available
out_ready  in  1  consumer takes sample this cycle
out_data  out  16  consumer sample
Waddr_out  out  ADDR_W  SRAM write address
Wdata_out  out  16  SRAM write data
doWrite  out  1  write strobe to SRAM interface
Raddr_out  out  ADDR_W  SRAM read address
doRead  out  1  read strobe to SRAM interface
Rdata_in  in  16  read data returned by SRAM interface
count  out  ADDR_W+1  words stored in SRAM (excludes holding regs)
full  out  1  count == 2**ADDR_W
empty  out  1  count == 0
level_hi  out  1  watermark flag (see Optional Feature)

Behaviour:
- Reset: all outputs 0 except in_ready=1 and empty=1; wr_ptr=rd_ptr=0; FSM=IDLE; in-flight access abandoned, strobes drop the same cycle reset is sampled.
- Input holding register (1 entry): in_ready = !in_hold_v. Handshake in_valid&&in_ready loads in_hold, sets in_hold_v.
- Output register (1 entry): out_valid = out_hold_v; out_valid&&out_ready clears it. out_data stable while out_valid && !out_ready.
- FSM states: IDLE, WR_SETUP, WR_STROBE, WR_DONE, RD_SETUP, RD_STROBE, RD_CAPT.
- IDLE: want_wr = in_hold_v && !full; want_rd = !out_hold_v && !empty. Both true -> alternate, starting with write after reset (last_op toggle). Neither -> stay.
- WR_SETUP (1 cyc): Waddr_out=wr_ptr, Wdata_out=in_hold, doWrite=0. WR_STROBE (STROBE_CYC cyc): doWrite=1, address/data held. WR_DONE (1 cyc): doWrite=0, data/address still held; wr_ptr+1, count+1, in_hold_v cleared -> IDLE.
- RD_SETUP (1 cyc): Raddr_out=rd_ptr. RD_STROBE (STROBE_CYC cyc): doRead=1. RD_CAPT (1 cyc): doRead=0, out_data<=Rdata_in, out_hold_v=1, rd_ptr+1, count-1 -> IDLE.
- Access latency: write STROBE_CYC+2 cycles; read STROBE_CYC+2 cycles from IDLE decision to out_valid.
- Pointers wrap modulo 2**ADDR_W naturally; full/empty derived from count, never from pointer equality.
- Full: in_hold stays occupied, in_ready stays 0 (backpressure, no drop). Empty: no read issued; out_valid stays 0.
- Count never changes by more than 1 per cycle; write and read never overlap.
- Addresses/data registered; no combinational path from in_* or out_ready to SRAM-side outputs.

Optional Feature:
SRAM_FIFO_WATERMARK_EN: defined -> level_hi registered, 1 when count >= HI_MARK, 0 otherwise, updates cycle after count changes. Undefined -> level_hi tied 0, no comparator.

Test Plan:
- Reset then idle 20 cyc -> in_ready=1, empty=1, count=0, doWrite=doRead=0, out_valid=0.
- Push 0x1234 -> doWrite high exactly 2 cyc with Waddr_out=0, Wdata_out=0x1234; model returns it; out_valid with out_data=0x1234, count back to 0.
- Stream 1000 ramp samples, out_ready random 50% -> output matches input order, no loss, no duplicates; strobes never overlap.
- ADDR_W=4, out_ready=0, push 20 -> count=16, full=1, in_hold occupied, in_ready=0; release -> 0..19 in order, ptr wrap at 16 correct.
- Assert reset during WR_STROBE -> doWrite=0 next cycle, count=0, wr_ptr=0.
- With SRAM_FIFO_WATERMARK_EN, ADDR_W=4, HI_MARK=8: level_hi rises cycle after count reaches 8, falls cycle after count drops to 7.

Source files
------------

// File: rtl/sram_sample_fifo.sv
// Ring-buffer audio sample FIFO using an external SRAM, one access at a time.
// Defining SRAM_FIFO_WATERMARK_EN enables the registered level_hi watermark flag.
module sram_sample_fifo #(
  parameter int ADDR_W     = 18,
  parameter int STROBE_CYC = 2,
  parameter int HI_MARK    = 131072
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [ADDR_W-1:0] Waddr_out,
  output logic [15:0]       Wdata_out,
  output logic              doWrite,
  output logic [ADDR_W-1:0] Raddr_out,
  output logic              doRead,
  input  logic [15:0]       Rdata_in,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              level_hi
);

  // state     | meaning
  // IDLE      | choose next access (write/read alternate when both pending)
  // WR_SETUP  | write address/data presented, strobe low
  // WR_STROBE | doWrite high for STROBE_CYC cycles
  // WR_DONE   | strobe low, address/data held; commit write
  // RD_SETUP  | read address presented, strobe low
  // RD_STROBE | doRead high for STROBE_CYC cycles
  // RD_CAPT   | strobe low; capture Rdata_in into output register
  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_STROBE, WR_DONE, RD_SETUP, RD_STROBE, RD_CAPT
  } state_e;

  localparam int              CW        = ADDR_W + 1;
  localparam logic [CW-1:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0]      STRB_LOAD = 3'(STROBE_CYC - 1);

  if (STROBE_CYC < 1 || STROBE_CYC > 7 || HI_MARK < 0 || HI_MARK > (1 << ADDR_W)) begin : g_param_check
    $error("sram_sample_fifo: parameter out of range");
  end

  state_e              state_q, state_d;
  logic [2:0]          strb_cnt_q, strb_cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [15:0]         in_hold_q, in_hold_d;
  logic                in_hold_v_q, in_hold_v_d;
  logic [15:0]         out_data_q, out_data_d;
  logic                out_hold_v_q, out_hold_v_d;
  logic                last_wr_q, last_wr_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                do_write_q, do_write_d;
  logic                do_read_q, do_read_d;
  logic                full_w, empty_w, want_wr, want_rd;

  assign full_w  = (count_q == DEPTH);
  assign empty_w = (count_q == '0);
  assign want_wr = in_hold_v_q && !full_w;
  assign want_rd = !out_hold_v_q && !empty_w;

  always_comb begin
    state_d      = state_q;
    strb_cnt_d   = strb_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    in_hold_d    = in_hold_q;
    in_hold_v_d  = in_hold_v_q;
    out_data_d   = out_data_q;
    out_hold_v_d = out_hold_v_q;
    last_wr_d    = last_wr_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    raddr_d      = raddr_q;
    do_write_d   = 1'b0;
    do_read_d    = 1'b0;

    if (in_valid && !in_hold_v_q) begin
      in_hold_d   = in_data;
      in_hold_v_d = 1'b1;
    end
    if (out_hold_v_q && out_ready) begin
      out_hold_v_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // last_wr_q resets low so a contended first decision goes to the write
        if (want_wr && (!want_rd || !last_wr_q)) begin
          state_d   = WR_SETUP;
          waddr_d   = wr_ptr_q;
          wdata_d   = in_hold_q;
          last_wr_d = 1'b1;
        end else if (want_rd) begin
          state_d   = RD_SETUP;
          raddr_d   = rd_ptr_q;
          last_wr_d = 1'b0;
        end
      end
      WR_SETUP: begin
        state_d    = WR_STROBE;
        strb_cnt_d = STRB_LOAD;
        do_write_d = 1'b1;
      end
      WR_STROBE: begin
        if (strb_cnt_q == '0) begin
          state_d = WR_DONE;
        end else begin
          strb_cnt_d = strb_cnt_q - 3'd1;
          do_write_d = 1'b1;
        end
      end
      WR_DONE: begin
        state_d     = IDLE;
        wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
        count_d     = count_q + CW'(1);
        in_hold_v_d = 1'b0;
      end
      RD_SETUP: begin
        state_d    = RD_STROBE;
        strb_cnt_d = STRB_LOAD;
        do_read_d  = 1'b1;
      end
      RD_STROBE: begin
        if (strb_cnt_q == '0) begin
          state_d = RD_CAPT;
        end else begin
          strb_cnt_d = strb_cnt_q - 3'd1;
          do_read_d  = 1'b1;
        end
      end
      RD_CAPT: begin
        state_d      = IDLE;
        out_data_d   = Rdata_in;
        out_hold_v_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
        count_d      = count_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      strb_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      in_hold_q    <= '0;
      in_hold_v_q  <= 1'b0;
      out_data_q   <= '0;
      out_hold_v_q <= 1'b0;
      last_wr_q    <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      raddr_q      <= '0;
      do_write_q   <= 1'b0;
      do_read_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      strb_cnt_q   <= strb_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      in_hold_q    <= in_hold_d;
      in_hold_v_q  <= in_hold_v_d;
      out_data_q   <= out_data_d;
      out_hold_v_q <= out_hold_v_d;
      last_wr_q    <= last_wr_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      raddr_q      <= raddr_d;
      do_write_q   <= do_write_d;
      do_read_q    <= do_read_d;
    end
  end

`ifdef SRAM_FIFO_WATERMARK_EN
  localparam logic [CW-1:0] HI_W = CW'(HI_MARK);
  logic level_hi_q, level_hi_d;

  always_comb begin
    level_hi_d = (count_q >= HI_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_hi_q <= 1'b0;
    end else begin
      level_hi_q <= level_hi_d;
    end
  end

  assign level_hi = level_hi_q;
`else
  assign level_hi = 1'b0;
`endif

  assign in_ready  = !in_hold_v_q;
  assign out_valid = out_hold_v_q;
  assign out_data  = out_data_q;
  assign Waddr_out = waddr_q;
  assign Wdata_out = wdata_q;
  assign doWrite   = do_write_q;
  assign Raddr_out = raddr_q;
  assign doRead    = do_read_q;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;

endmodule
